// File: rtl/mv_result_drain.sv
// mv_result_drain: reads the N result words of the matrix-vector multiplier
// back out of the result RAM, streams them over a valid/ready interface and
// keeps track of the largest element and its index.
//
// Reads are issued against a credit counted over the 2-entry output buffer
// plus the one read that can be in flight across the RAM latency. The buffer
// therefore never overflows, and the consumer may stall at any time.

module mv_result_drain #(
  parameter  int N          = 3,
  parameter  int DW         = 8,
  parameter  int BRAM_DEPTH = 32,
  localparam int RW         = 2*DW + $clog2(N),
  localparam int AW         = $clog2(BRAM_DEPTH),
  localparam int IW         = $clog2(N) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,        // asynchronous, active low
  input  logic          start_i,
  input  logic [AW-1:0] base_addr_i,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [RW-1:0] rd_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [RW-1:0] out_data_o,
  output logic [IW-1:0] out_idx_o,
  output logic          out_last_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [RW-1:0] max_val_o,
  output logic [IW-1:0] max_idx_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [AW-1:0] addr_q;       // base address plus issue count, wrapped
  logic [IW-1:0] issue_cnt_q;  // reads issued this drain
  logic [IW-1:0] ret_cnt_q;    // RAM words returned into the buffer
  logic [IW-1:0] acc_cnt_q;    // words accepted by the consumer
  logic          rd_pend_q;    // a read was issued last cycle; its data is on rd_data_i now
  logic          busy_q;
  logic          done_q;
  logic [RW-1:0] max_val_q;
  logic [IW-1:0] max_idx_q;

  // Output buffer: slot 0 is the head and drives the stream outputs.
  logic [1:0]    occ_q;
  logic [RW-1:0] s0_data_q, s1_data_q;
  logic [IW-1:0] s0_idx_q,  s1_idx_q;

  logic          pop;
  logic [1:0]    inflight_sum;
  logic          credit;

  // A word leaves the buffer only when it is both offered and taken.
  assign pop = out_valid_o && out_ready_i;

  // Occupancy plus the read whose data lands this cycle; a pop in the same
  // cycle frees a slot early enough for one more read.
  assign inflight_sum = occ_q + {1'b0, rd_pend_q};
  assign credit       = (inflight_sum < 2'd2) || ((inflight_sum == 2'd2) && pop);

  // Reads are issued combinationally so that the pop-this-cycle credit can be
  // used immediately, keeping one word per cycle with the consumer ready.
  assign rd_en_o   = (state_q == S_READ) && credit;
  assign rd_addr_o = addr_q;

  assign out_valid_o = (occ_q != 2'd0);
  assign out_data_o  = s0_data_q;
  assign out_idx_o   = s0_idx_q;
  assign out_last_o  = out_valid_o && (s0_idx_q == IW'(N-1));

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign max_val_o = max_val_q;
  assign max_idx_o = max_idx_q;

  // Drain sequencing: read issue, return/accept counting and max tracking.
  // NOTE: every sequential assignment uses <= so all registers update from the
  // same pre-edge values regardless of statement order within the block.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      acc_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      max_val_q   <= '0;
      max_idx_q   <= '0;
    end else begin
      done_q    <= 1'b0;
      rd_pend_q <= rd_en_o;

      if (rd_en_o) begin
        addr_q      <= (addr_q == AW'(BRAM_DEPTH-1)) ? '0 : addr_q + 1'b1;
        issue_cnt_q <= issue_cnt_q + 1'b1;
      end

      if (rd_pend_q) begin
        ret_cnt_q <= ret_cnt_q + 1'b1;
      end

      // Words arrive in index order, so a strict compare keeps the lowest
      // index on ties; the first accepted word always loads.
      if (pop) begin
        acc_cnt_q <= acc_cnt_q + 1'b1;
        if ((acc_cnt_q == '0) || (out_data_o > max_val_q)) begin
          max_val_q <= out_data_o;
          max_idx_q <= out_idx_o;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q     <= S_READ;
            addr_q      <= base_addr_i;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            acc_cnt_q   <= '0;
            max_val_q   <= '0;
            max_idx_q   <= '0;
            busy_q      <= 1'b1;
          end
        end
        S_READ: begin
          if (rd_en_o && (issue_cnt_q == IW'(N-1))) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && (acc_cnt_q == IW'(N-1))) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Two-slot FIFO: write lands the cycle after a read, pop shifts slot 1 forward.
  // NOTE: the buffer slots are reset even though occupancy alone guards them,
  // because the stream outputs are driven straight from slot 0 and must read 0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      occ_q     <= 2'd0;
      s0_data_q <= '0;
      s0_idx_q  <= '0;
      s1_data_q <= '0;
      s1_idx_q  <= '0;
    end else begin
      case ({rd_pend_q, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            s0_data_q <= rd_data_i;
            s0_idx_q  <= ret_cnt_q;
          end else begin
            s1_data_q <= rd_data_i;
            s1_idx_q  <= ret_cnt_q;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          s0_data_q <= s1_data_q;
          s0_idx_q  <= s1_idx_q;
          occ_q     <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            s0_data_q <= rd_data_i;
            s0_idx_q  <= ret_cnt_q;
          end else begin
            s0_data_q <= s1_data_q;
            s0_idx_q  <= s1_idx_q;
            s1_data_q <= rd_data_i;
            s1_idx_q  <= ret_cnt_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mv_result_drain.sv
// Testbench for mv_result_drain: a behavioural RAM, a table of drain
// scenarios with hand-derived max results, hand-written reset and timing
// sequences, and randomized drains checked against a list-level model.

module tb_mv_result_drain;

  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int RW    = 2*DW + $clog2(N);
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [RW-1:0] rd_data = '0;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [RW-1:0] max_val;
  logic [IW-1:0] max_idx;

  mv_result_drain #(.N(N), .DW(DW), .BRAM_DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .start_i     (start),
    .base_addr_i (base_addr),
    .rd_en_o     (rd_en),
    .rd_addr_o   (rd_addr),
    .rd_data_i   (rd_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last),
    .busy_o      (busy),
    .done_o      (done),
    .max_val_o   (max_val),
    .max_idx_o   (max_idx)
  );

  always #5 clk = ~clk;

  // Result RAM with one cycle of read latency.
  logic [RW-1:0] ram [DEPTH];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int            base;
    logic [RW-1:0] d0, d1, d2;
    int            mode;     // 0: ready high, 1: fixed stall pattern, 2: random
    bit            ign;      // extra start pulses at t+2 and in the DONE cycle
    logic [RW-1:0] exp_max;
    int            exp_idx;
  } vec_t;

  function automatic vec_t mk(int base, logic [RW-1:0] d0, logic [RW-1:0] d1, logic [RW-1:0] d2,
                              int mode, bit ign, logic [RW-1:0] exp_max, int exp_idx);
    vec_t v;
    v.base = base; v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.mode = mode; v.ign = ign; v.exp_max = exp_max; v.exp_idx = exp_idx;
    return v;
  endfunction

  // Reference: max of a list in index order, first element loads, strict
  // greater-than replaces so ties keep the earliest index.
  function automatic vec_t with_model_max(vec_t v);
    logic [RW-1:0] lst [N];
    vec_t r;
    r = v;
    lst[0] = v.d0; lst[1] = v.d1; lst[2] = v.d2;
    r.exp_max = lst[0];
    r.exp_idx = 0;
    for (int i = 1; i < N; i++) begin
      if (lst[i] > r.exp_max) begin
        r.exp_max = lst[i];
        r.exp_idx = i;
      end
    end
    return r;
  endfunction

  // Monitor state, owned by the negedge monitor, reset by begin_drain.
  bit            mon_en = 1'b0;
  int            t_cyc;
  int            exp_base;
  logic [RW-1:0] exp_data [N];
  int            n_issued, n_accepted, n_done;
  int            first_rd_rel, first_val_rel, last_rel, done_rel, busy_fall_rel;
  bit            prev_stall, busy_prev;
  logic [RW-1:0] prev_data;
  logic [IW-1:0] prev_idx;

  bit bp_pat [6];

  // Scoreboard sampled on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    int rel;
    bit pop;
    if (mon_en) begin
      rel = cyc - t_cyc + 1;
      pop = out_valid && out_ready;
      if (rd_en) begin
        check("rd_addr", rd_addr, (exp_base + n_issued) % DEPTH);
        check("issue_limit", n_issued < N, 1);
        check("credit", (n_issued - n_accepted - int'(pop)) < 2, 1);
        if (first_rd_rel < 0) first_rd_rel = rel;
        n_issued++;
      end
      if (out_valid && first_val_rel < 0) first_val_rel = rel;
      if (out_valid && prev_stall) begin
        check("hold_data", out_data, prev_data);
        check("hold_idx", out_idx, prev_idx);
      end
      if (pop) begin
        check("no_extra_word", n_accepted < N, 1);
        if (n_accepted < N) begin
          check("out_data", out_data, exp_data[n_accepted]);
          check("out_idx", out_idx, n_accepted);
          check("out_last", out_last, n_accepted == N-1);
        end
        if (out_last) last_rel = rel;
        n_accepted++;
      end
      if (done) begin
        n_done++;
        done_rel = rel;
      end
      if (busy_prev && !busy) busy_fall_rel = rel;
      busy_prev  = busy;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_idx;
    end
  end

  function automatic bit ready_for(int mode, int k);
    if (mode == 1) return (k >= 3 && k <= 8) ? bp_pat[k-3] : 1'b1;
    if (mode == 2) return $urandom_range(0, 99) < 60;
    return 1'b1;
  endfunction

  // Load RAM, arm the monitor, pulse start; returns in cycle t+1 (+1 time unit).
  task automatic begin_drain(input vec_t v);
    for (int i = 0; i < DEPTH; i++) ram[i] = RW'($urandom);
    ram[v.base % DEPTH]       = v.d0;
    ram[(v.base + 1) % DEPTH] = v.d1;
    ram[(v.base + 2) % DEPTH] = v.d2;
    exp_base = v.base;
    for (int i = 0; i < N; i++) exp_data[i] = ram[(v.base + i) % DEPTH];
    n_issued = 0; n_accepted = 0; n_done = 0;
    first_rd_rel = -1; first_val_rel = -1; last_rel = -1; done_rel = -1; busy_fall_rel = -1;
    prev_stall = 1'b0; busy_prev = 1'b0;
    @(posedge clk); #1;
    base_addr = AW'(v.base);
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    t_cyc  = cyc;
    mon_en = 1'b1;
    start  = 1'b0;
  endtask

  task automatic run_drain(input vec_t v);
    begin_drain(v);
    for (int k = 1; k <= 60; k++) begin
      if (n_done > 0 && k > done_rel + 3) break;
      out_ready = ready_for(v.mode, k);
      start     = v.ign && (k == 2 || k == 6);
      base_addr = v.ign ? AW'($urandom) : AW'(v.base);
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    start  = 1'b0;
    check("done_count", n_done, 1);
    check("accepted", n_accepted, N);
    check("max_val", max_val, v.exp_max);
    check("max_idx", max_idx, v.exp_idx);
    check("busy_after", busy, 0);
    check("first_rd_rel", first_rd_rel, 1);
    check("first_valid_rel", first_val_rel, 3);
    if (v.mode == 0) begin
      check("last_rel", last_rel, N + 2);
      check("done_rel", done_rel, N + 3);
      check("busy_fall_rel", busy_fall_rel, N + 4);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {rd_en, out_valid, out_last, busy, done}, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_idx"}, out_idx, 0);
    check({tag, "_max_val"}, max_val, 0);
    check({tag, "_max_idx"}, max_idx, 0);
  endtask

  vec_t tbl [7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bp_pat[0] = 1'b0; bp_pat[1] = 1'b0; bp_pat[2] = 1'b1;
    bp_pat[3] = 1'b0; bp_pat[4] = 1'b1; bp_pat[5] = 1'b1;

    //             base  d0    d1    d2       mode ign  max     idx
    tbl[0] = mk(0,  5,    9,    2,       0,   0,   9,      1);  // basic + timing
    tbl[1] = mk(0,  5,    9,    2,       1,   0,   9,      1);  // backpressure
    tbl[2] = mk(30, 7,    7,    3,       0,   0,   7,      0);  // wrap and tie
    tbl[3] = mk(0,  5,    9,    2,       0,   1,   9,      1);  // ignored starts
    tbl[4] = mk(31, 0,    0,    0,       1,   0,   0,      0);  // all zero, wrap
    tbl[5] = mk(12, 1,    2,    262143,  2,   0,   262143, 2);  // full-scale last
    tbl[6] = mk(20, 100,  50,   100,     1,   0,   100,    0);  // tie first/last

    rst_n = 1'b0; start = 1'b0; base_addr = '0; out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    #12;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_drain(tbl[i]);

    // Reset in the middle of a drain, right after the first word is taken.
    begin_drain(tbl[0]);
    for (int k = 1; k <= 20 && n_accepted == 0; k++) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    check("rst_first_accept", n_accepted, 1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("mid_rst_hold");
    rst_n = 1'b1;
    run_drain(tbl[0]);

    // Randomized drains against the list model.
    for (int r = 0; r < 10; r++) begin
      v.base = int'($urandom_range(0, DEPTH-1));
      v.d0   = $urandom_range(0, 1) ? RW'($urandom_range(0, 3)) : RW'($urandom);
      v.d1   = $urandom_range(0, 1) ? RW'($urandom_range(0, 3)) : RW'($urandom);
      v.d2   = $urandom_range(0, 1) ? RW'($urandom_range(0, 3)) : RW'($urandom);
      v.mode = 2;
      v.ign  = 1'b0;
      run_drain(with_model_max(v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
